pdm_decimator: RTL and testbench

- Receiving end of the 1-bit PDM link produced by pdm_dac: recovers signed PCM samples from a PDM bitstream by counting ones over a fixed window (boxcar/first-order CIC decimation).
- Used for loopback self-test of voice/mixer/DAC chains.
- Also usable as a low-rate audio/CV input from an external sigma-delta source on a pin.
- Output samples use the same signed DATA_BITS format as voice and mixer outputs. A valid/ready handshake carries them to downstream logic.

---
 rtl/pdm_decimator.sv | 76 +++++++
 tb/tb_pdm_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// Boxcar (first-order CIC) decimator: counts ones in a PDM bitstream over a
// 2^DECIM_LOG2-cycle window and emits signed samples over a valid/ready handshake.
module pdm_decimator #(
    parameter int DATA_BITS   = 12,
    parameter int DECIM_LOG2  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        pdm_in,
    output logic signed [DATA_BITS-1:0] dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic                        overrun
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_bit;
    logic [DECIM_LOG2-1:0]  wcnt;
    logic [DECIM_LOG2:0]    ocnt;
    logic [DECIM_LOG2:0]    total;
    logic [DECIM_LOG2-1:0]  sat;
    logic [DATA_BITS-1:0]   offset_bin;
    logic [DATA_BITS-1:0]   sample;
    logic                   last;
    logic                   done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_in};
        end
    end

    assign s_bit = sync_q[SYNC_STAGES-1];
    assign last  = &wcnt;
    assign done  = en & last;

    // An all-ones window counts 2^DECIM_LOG2, one past the largest code.
    assign total      = ocnt + {{DECIM_LOG2{1'b0}}, s_bit};
    assign sat        = total[DECIM_LOG2] ? '1 : total[DECIM_LOG2-1:0];
    assign offset_bin = DATA_BITS'(sat) << (DATA_BITS - DECIM_LOG2);
    assign sample     = {~offset_bin[DATA_BITS-1], offset_bin[DATA_BITS-2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
            ocnt <= '0;
        end else if (!en) begin
            wcnt <= '0;
            ocnt <= '0;
        end else begin
            wcnt <= wcnt + 1'b1;
            ocnt <= last ? '0 : total;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= done & dout_valid & ~dout_ready;
            if (done) begin
                dout       <= sample;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: window-sum reference model, loopback first-order
// modulator, handshake/reset/enable scenarios and a DECIM_LOG2=8 instance.
module tb_pdm_decimator;
    localparam int DB = 12;
    localparam int DL = 12;
    localparam int SS = 2;
    localparam int N  = 1 << DL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic pdm_in = 1'b0;
    logic dout_ready = 1'b0;
    logic signed [DB-1:0] dout, dout8;
    logic dout_valid, overrun, dout_valid8, overrun8;

    always #5 clk = ~clk;

    pdm_decimator #(.DATA_BITS(DB), .DECIM_LOG2(DL), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .overrun(overrun)
    );

    pdm_decimator #(.DATA_BITS(DB), .DECIM_LOG2(8), .SYNC_STAGES(SS)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in), .dout(dout8),
        .dout_valid(dout_valid8), .dout_ready(dout_ready), .overrun(overrun8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: s_bit is pdm_in delayed SS edges; a sample is the
    // ones count of the last N enabled edges, mapped to signed PCM.
    bit sq[$];
    int m_n, m_ones, m_dout, cyc, ov_cnt;
    bit m_valid, m_ovr, m_done;
    int din, dac_acc, pdm_mode;

    function automatic int to_sample(input int ones, input int dl);
        int o;
        o = (ones > (1 << dl) - 1) ? (1 << dl) - 1 : ones;
        return o * (1 << (DB - dl)) - (1 << (DB - 1));
    endfunction

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < SS; i++) sq.push_back(1'b0);
        m_n = 0; m_ones = 0; m_dout = 0; m_valid = 0; m_ovr = 0;
    endtask

    task automatic tick();
        bit s, c;
        @(posedge clk);
        cyc++;
        m_done = 0;
        if (!rst) begin
            model_reset();
        end else begin
            s = sq.pop_front();
            sq.push_back(pdm_in);
            m_ovr = 0;
            if (en) begin
                m_ones += int'(s);
                m_n++;
                if (m_n == N) m_done = 1;
            end else begin
                m_n = 0; m_ones = 0;
            end
            if (m_done) begin
                m_ovr   = m_valid && !dout_ready;
                m_valid = 1;
                m_dout  = to_sample(m_ones, DL);
                m_n = 0; m_ones = 0;
            end else if (m_valid && dout_ready) begin
                m_valid = 0;
            end
        end
        #1;
        check("dout", int'(dout), m_dout);
        check("dout_valid", int'(dout_valid), int'(m_valid));
        check("overrun", int'(overrun), int'(m_ovr));
        if (overrun) ov_cnt++;
        dac_acc += din + (1 << (DB - 1));
        c = (dac_acc >= (1 << DB));
        if (c) dac_acc -= (1 << DB);
        case (pdm_mode)
            0:       pdm_in = c;
            1:       pdm_in = 1'b1;
            default: pdm_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic wait_done(input int limit, input bit rand_ready, output int waited);
        waited = 0;
        do begin
            if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
            tick();
            waited++;
        end while (!m_done && waited < limit);
        if (!m_done) check("timeout_done", 0, 1);
    endtask

    task automatic wait_n(input int target, input int limit);
        int k;
        k = 0;
        while (m_n != target && k < limit) begin
            tick();
            k++;
        end
        if (m_n != target) check("timeout_wcnt", m_n, target);
    endtask

    initial begin
        int w, last8, n8, d, rd;
        model_reset();
        din = 0; pdm_mode = 0; dac_acc = 0; cyc = 0; ov_cnt = 0;
        dout_ready = 1'b1;
        #1;
        check("reset_dout", int'(dout), 0);
        check("reset_valid", int'(dout_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        repeat (3) tick();
        rst = 1'b1; en = 1'b1;

        // din = 0 loopback
        wait_done(N + 10, 0, w);
        check("first_latency", w, N);
        wait_done(N + 10, 0, w);
        check("period", w, N);
        check("din_zero", int'(dout), 0);
        check("no_overrun", ov_cnt, 0);

        // constant inputs
        din = 1000;
        wait_done(N + 10, 0, w); wait_done(N + 10, 0, w);
        check("din_1000", int'(dout), 1000);
        din = -2048;
        wait_done(N + 10, 0, w); wait_done(N + 10, 0, w);
        check("din_m2048", int'(dout), -2048);
        pdm_mode = 1;
        wait_done(N + 10, 0, w); wait_done(N + 10, 0, w);
        check("stuck_one", int'(dout), 2047);

        // DECIM_LOG2 = 8 instance
        pdm_mode = 0; din = 512; last8 = -1; n8 = 0;
        repeat (1100) begin
            tick();
            check("d8_overrun", int'(overrun8), 0);
            if (dout_valid8) begin
                if (last8 >= 0) check("d8_period", cyc - last8, 256);
                if (n8 >= 2) begin
                    d = int'(dout8) - 512;
                    check("d8_range", int'(d <= 16 && d >= -16), 1);
                end
                last8 = cyc; n8++;
            end
        end
        check("d8_count", int'(n8 >= 4), 1);

        // overwrite with dout_ready low
        din = -500; dout_ready = 1'b0;
        wait_done(N + 10, 0, w);
        ov_cnt = 0;
        wait_done(N + 10, 0, w);
        check("overrun_once", ov_cnt, 1);
        check("held_valid", int'(dout_valid), 1);
        check("overwrite_val", int'(dout), -500);
        wait_n(N - 1, N + 10);
        dout_ready = 1'b1;
        tick();
        check("coinc_overrun", int'(overrun), 0);
        check("coinc_valid", int'(dout_valid), 1);
        tick();
        check("consumed", int'(dout_valid), 0);

        // asynchronous reset mid-window
        din = 1000; dout_ready = 1'b0;
        wait_done(N + 10, 0, w);
        wait_n(1500, N + 10);
        #2 rst = 1'b0;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_valid", int'(dout_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        tick();
        rst = 1'b1; dout_ready = 1'b1;
        wait_done(N + 10, 0, w);
        check("arst_latency", w, N);
        d = int'(dout) - 1000;
        check("arst_clean", int'(d <= 2 && d >= -2), 1);

        // enable drop mid-window with a pending sample
        dout_ready = 1'b0;
        wait_done(N + 10, 0, w);
        wait_n(2000, N + 10);
        en = 1'b0; ov_cnt = 0;
        repeat (100) tick();
        check("en_off_nosample", ov_cnt, 0);
        check("en_off_valid", int'(dout_valid), 1);
        en = 1'b1;
        wait_done(N + 10, 0, w);
        check("en_full_window", w, N);
        check("en_overrun", int'(overrun), 1);

        // random bitstream and random consumer
        pdm_mode = 2;
        wait_done(N + 10, 1, w);
        pdm_mode = 0;
        rd = int'($urandom_range(0, 4095)) - 2048;
        din = rd;
        wait_done(N + 10, 1, w); wait_done(N + 10, 1, w);
        check("rand_din", int'(dout), rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
